// File: rtl/sp_frame_receiver.sv
// Serial-to-parallel frame receiver.
// Frames are: start bit (0), DATA_W data bits LSB first, optional parity bit, stop bit (1).
// The line is sampled only on clock edges where bitEn is high. A good frame updates
// parallelOut and pulses frameValid. A bad stop bit or parity bit pulses an error flag
// instead. A line held low after a framing error is treated as a break, not as a new start.
module sp_frame_receiver #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  localparam int FRAME_W   = DATA_W + 2 + PARITY_EN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bitEn,
  input  logic               serialIn,
  output logic [FRAME_W-1:0] data,
  output logic [DATA_W-1:0]  parallelOut,
  output logic               frameValid,
  output logic               frameErr,
  output logic               parityErr,
  output logic               busy
);

  localparam int            CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic          ODD_BIT  = (PARITY_ODD != 0);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               par_q, par_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               perr_q, perr_d;

  // The frame register shifts right, so the first bit of the frame (start) ends up in bit 0.
  logic [FRAME_W-1:0] shifted;
  assign shifted = {serialIn, data_q[FRAME_W-1:1]};

  // par_q is the running XOR of the data bits and the parity bit. When parity is disabled,
  // every frame counts as having good parity.
  logic parity_ok;
  assign parity_ok = !HAS_PAR || (par_q == ODD_BIT);

  // Next-state logic: the frame walks through the states one sampled bit at a time.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. This means no path
    // can leave a variable unassigned, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    word_d  = word_q;
    par_d   = par_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;

    if (bitEn) begin
      unique case (state_q)
        S_IDLE: begin
          if (!serialIn) begin
            state_d = S_DATA;
            data_d  = shifted;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        S_DATA: begin
          data_d = shifted;
          par_d  = par_q ^ serialIn;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          data_d  = shifted;
          par_d   = par_q ^ serialIn;
          state_d = S_STOP;
        end
        S_STOP: begin
          data_d = shifted;
          if (serialIn) begin
            state_d = S_IDLE;
            if (parity_ok) begin
              word_d  = shifted[DATA_W:1];
              valid_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            state_d = S_BREAK;
            ferr_d  = 1'b1;
            perr_d  = !parity_ok;
          end
        end
        S_BREAK: begin
          if (serialIn) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register. An asynchronous reset aborts a frame in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      word_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the values that
      // were present before the edge, which is what real flops do.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      word_q  <= word_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign data        = data_q;
  assign parallelOut = word_q;
  assign frameValid  = valid_q;
  assign frameErr    = ferr_q;
  assign parityErr   = perr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sp_frame_receiver.sv
// Bench for sp_frame_receiver. It drives two instances:
//   A: 8 data bits, no parity.
//   B: 8 data bits, even parity.
// Each instance has its own serial line and shares clk, rst and bitEn.
// Frames are described at the word level. Their expected outcome is pushed into a
// per-instance queue, and a monitor pops an entry whenever a strobe appears.
module tb_sp_frame_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_en;
  logic        a_ser, b_ser;

  logic [9:0]  a_data;
  logic [7:0]  a_po;
  logic        a_fv, a_fe, a_pe, a_busy;

  logic [10:0] b_data;
  logic [7:0]  b_po;
  logic        b_fv, b_fe, b_pe, b_busy;

  sp_frame_receiver #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .bitEn(bit_en), .serialIn(a_ser),
    .data(a_data), .parallelOut(a_po), .frameValid(a_fv),
    .frameErr(a_fe), .parityErr(a_pe), .busy(a_busy)
  );

  sp_frame_receiver #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .bitEn(bit_en), .serialIn(b_ser),
    .data(b_data), .parallelOut(b_po), .frameValid(b_fv),
    .frameErr(b_fe), .parityErr(b_pe), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit          ferr;
    bit          perr;
    logic [7:0]  po;
    logic [15:0] data;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       ea, eb;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] good_a, good_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance A: every strobe must match the next expected frame outcome.
  always @(negedge clk) begin
    if (rst === 1'b0 && (a_fv | a_fe | a_pe) === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_strobe", {29'd0, a_fv, a_fe, a_pe}, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_frameValid", a_fv, ea.valid);
        check("a_frameErr", a_fe, ea.ferr);
        check("a_parityErr", a_pe, ea.perr);
        check("a_parallelOut", a_po, ea.po);
        check("a_data", a_data, ea.data[9:0]);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rst === 1'b0 && (b_fv | b_fe | b_pe) === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_strobe", {29'd0, b_fv, b_fe, b_pe}, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_frameValid", b_fv, eb.valid);
        check("b_frameErr", b_fe, eb.ferr);
        check("b_parityErr", b_pe, eb.perr);
        check("b_parallelOut", b_po, eb.po);
        check("b_data", b_data, eb.data[10:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit on the line and sample it on the gap-th clock from now.
  task automatic drive_bit(input bit inst, input bit b, input int gap);
    if (inst) b_ser = b; else a_ser = b;
    bit_en = 1'b0;
    repeat (gap - 1) tick();
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic line_bits(input bit inst, input int n, input bit b);
    for (int i = 0; i < n; i++) drive_bit(inst, b, 1);
  endtask

  // Send one frame and record the expected outcome.
  // Instance B uses even parity. par_flip inverts the correct parity bit.
  task automatic send_frame(input bit inst, input logic [7:0] word, input bit stop,
                            input bit par_flip, input int gap);
    bit   pbit;
    bit   pok;
    exp_t e;
    pbit = (^word) ^ par_flip;
    pok  = inst ? (((^word) ^ pbit) == 1'b0) : 1'b1;
    e.valid = stop && pok;
    e.ferr  = !stop;
    e.perr  = !pok;
    if (e.valid) begin
      if (inst) good_b = word; else good_a = word;
    end
    e.po   = inst ? good_b : good_a;
    e.data = inst ? 16'({stop, pbit, word, 1'b0}) : 16'({stop, word, 1'b0});

    drive_bit(inst, 1'b0, gap);
    check(inst ? "b_busy_after_start" : "a_busy_after_start", inst ? b_busy : a_busy, 1);
    for (int i = 0; i < 8; i++) drive_bit(inst, word[i], gap);
    if (inst) drive_bit(inst, pbit, gap);
    if (inst) qb.push_back(e); else qa.push_back(e);
    drive_bit(inst, stop, gap);
    check(inst ? "b_busy_after_stop" : "a_busy_after_stop", inst ? b_busy : a_busy, !stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         inst;
    logic [7:0] w;
    bit         stop, pflip;
    int         gap;

    rst    = 1'b1;
    bit_en = 1'b0;
    a_ser  = 1'b1;
    b_ser  = 1'b1;
    good_a = 8'h00;
    good_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_data", a_data, 0);
    check("rst_a_po", a_po, 0);
    check("rst_a_flags", {a_fv, a_fe, a_pe, a_busy}, 0);
    check("rst_b_data", b_data, 0);
    check("rst_b_flags", {b_fv, b_fe, b_pe, b_busy}, 0);
    rst = 1'b0;
    tick();

    // Basic frame 0x5A.
    send_frame(0, 8'h5A, 1'b1, 1'b0, 1);
    check("t1_po", a_po, 8'h5A);
    check("t1_data", a_data, 10'h2B4);

    // Idle line, then 0x55 followed back-to-back by a second frame.
    line_bits(0, 3, 1'b1);
    send_frame(0, 8'h55, 1'b1, 1'b0, 1);
    check("t2_po_first", a_po, 8'h55);
    send_frame(0, 8'hA6, 1'b1, 1'b0, 1);
    check("t2_po_second", a_po, 8'hA6);

    // Framing error, a held-low break, then recovery.
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1);
    check("t3_po_held", a_po, 8'hA6);
    line_bits(0, 20, 1'b0);
    check("t3_break_busy", a_busy, 1);
    line_bits(0, 1, 1'b1);
    check("t3_break_exit", a_busy, 0);
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1);
    check("t3_po_recovered", a_po, 8'h3C);

    // Even parity on instance B.
    send_frame(1, 8'h5A, 1'b1, 1'b0, 1);
    check("t4_par_ok_po", b_po, 8'h5A);
    send_frame(1, 8'h96, 1'b1, 1'b1, 1);
    check("t4_par_bad_po", b_po, 8'h5A);
    send_frame(1, 8'h01, 1'b0, 1'b1, 1);
    line_bits(1, 1, 1'b1);

    // bitEn asserted only every 4th clock.
    send_frame(0, 8'hC3, 1'b1, 1'b0, 4);
    check("t5_po", a_po, 8'hC3);

    // Reset in the middle of a frame.
    drive_bit(0, 1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(0, i[0], 1);
    rst = 1'b1;
    #1;
    check("t6_rst_po", a_po, 0);
    check("t6_rst_data", a_data, 0);
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_b_po", b_po, 0);
    good_a = 8'h00;
    good_b = 8'h00;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    a_ser = 1'b1;
    tick();
    send_frame(0, 8'h81, 1'b1, 1'b0, 1);
    check("t6_po", a_po, 8'h81);

    // Randomized frames on both instances.
    for (int k = 0; k < 60; k++) begin
      inst  = 1'($urandom_range(0, 1));
      w     = 8'($urandom);
      stop  = ($urandom_range(0, 5) != 0);
      pflip = inst && ($urandom_range(0, 4) == 0);
      gap   = $urandom_range(1, 3);
      line_bits(inst, $urandom_range(0, 2), 1'b1);
      send_frame(inst, w, stop, pflip, gap);
      if (!stop) begin
        line_bits(inst, $urandom_range(0, 3), 1'b0);
        line_bits(inst, 1, 1'b1);
      end
    end

    repeat (3) tick();
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
